// File: rtl/sr_ff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_ff_pkg
//  Description : Shared definitions for the SR flip-flop stage and its
//                upstream command generator (sr_cmd_gen).
//                - sr_cmd_e   : {s,r} command code as seen by the flop
//                - sr_state_e : sr_cmd_gen state machine encoding
//                - PRIO_*     : values accepted by SET_PRIORITY
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package sr_ff_pkg;

  // Command code on the flop inputs, packed as {s, r}.
  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RESET   = 2'b01,
    SET     = 2'b10,
    INVALID = 2'b11
  } sr_cmd_e;

  // Command generator state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PULSE_SET = 2'd1,
    ST_PULSE_CLR = 2'd2,
    ST_GAP       = 2'd3
  } sr_state_e;

  // Arbitration winner when set and clear are pending together.
  localparam bit PRIO_CLR = 1'b0;
  localparam bit PRIO_SET = 1'b1;

  // Map an {s, r} pair onto the flop command code.
  function automatic sr_cmd_e sr_cmd_of(input logic s, input logic r);
    return sr_cmd_e'({s, r});
  endfunction

endpackage : sr_ff_pkg
`default_nettype wire

// File: rtl/sr_cmd_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_gen_if
//  Description : Request/command bundle between the request source and the
//                SR command generator.
//  Signals     : set_req  raw set request (asynchronous to clk)
//                clr_req  raw clear request (asynchronous to clk)
//                s        set command to the flop
//                r        reset command to the flop
//                busy     pulse or gap cycle in progress
//                conflict simultaneous requests were arbitrated
//  Modports    : master - request source / command consumer side
//                slave  - sr_cmd_gen side
//  Revision    : 1.0  initial release
// ============================================================================
interface sr_cmd_gen_if;

  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (
    output set_req,
    output clr_req,
    input  s,
    input  r,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_req,
    input  clr_req,
    output s,
    output r,
    output busy,
    output conflict
  );

endinterface : sr_cmd_gen_if
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sr_debounce
//  Description : One request line: 2-flop synchroniser, level debouncer and
//                rising-edge detector on the accepted level.
//  Parameters  : DEBOUNCE_CYCLES  cycles a new level must persist (1..255)
//  Ports       : clk   system clock
//                rst   asynchronous active-high reset
//                din   raw asynchronous input
//                rise  one-cycle strobe, high on the edge where the
//                      accepted level toggles 0->1
//  Revision    : 1.0  initial release
// ============================================================================
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             lvl;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  assign differs = sync[1] ^ lvl;

  // The edge that would bring the count to DEBOUNCE_CYCLES is the accepting
  // edge itself, so lvl toggles there and the counter never exceeds
  // DEBOUNCE_CYCLES-1 (no wrap possible).
  assign accept = differs && (cnt == CNT_LAST);

  // Combinational so the pending flag downstream registers on the same edge
  // that lvl toggles.
  assign rise = accept && !lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
      lvl  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], din};
      if (!differs) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : sr_debounce
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_gen
//  Description : Turns two raw, bouncy request lines into clean, mutually
//                exclusive set/reset command pulses for an SR flop. Never
//                produces the s=r=1 code.
//  Parameters  : DEBOUNCE_CYCLES  debounce length in cycles (1..255)
//                PULSE_CYCLES     width of each command pulse (1..15)
//                SET_PRIORITY     PRIO_CLR: clear wins, PRIO_SET: set wins
//  Ports       : clk  system clock
//                rst  asynchronous active-high reset
//                bus  sr_cmd_gen_if.slave
//                     (set_req, clr_req in; s, r, busy, conflict out)
//  Revision    : 1.0  initial release
// ============================================================================
module sr_cmd_gen
  import sr_ff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter bit SET_PRIORITY    = PRIO_CLR
) (
  input  logic         clk,
  input  logic         rst,
  sr_cmd_gen_if.slave  bus
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] PULSE_SET = ST_PULSE_SET;
  localparam logic [1:0] PULSE_CLR = ST_PULSE_CLR;
  localparam logic [1:0] GAP       = ST_GAP;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  logic       set_rise;
  logic       clr_rise;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [3:0] pcnt;
  logic [3:0] pcnt_nx;
  logic       conflict_nx;

  logic       pend_set;
  logic       pend_clr;

  logic       s_q;
  logic       r_q;
  logic       busy_q;
  logic       conflict_q;

  // --------------------------------------------------------------------------
  // Per-line synchroniser + debouncer + rising-edge detector
  // --------------------------------------------------------------------------
  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_set_db (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.set_req),
    .rise (set_rise)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.clr_req),
    .rise (clr_rise)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    pcnt_nx     = pcnt;
    conflict_nx = 1'b0;
    case (state)
      IDLE: begin
        pcnt_nx = '0;
        if (pend_set && pend_clr) begin
          conflict_nx = 1'b1;
          state_nx    = (SET_PRIORITY == PRIO_SET) ? PULSE_SET : PULSE_CLR;
        end else if (pend_set) begin
          state_nx = PULSE_SET;
        end else if (pend_clr) begin
          state_nx = PULSE_CLR;
        end
      end
      PULSE_SET, PULSE_CLR: begin
        if (pcnt == PULSE_LAST) begin
          state_nx = GAP;
          pcnt_nx  = '0;
        end else begin
          pcnt_nx = pcnt + 4'd1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        pcnt_nx  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, pending flags and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      pend_set   <= 1'b0;
      pend_clr   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_nx;
      pcnt       <= pcnt_nx;
      // Every pending flag seen in IDLE is consumed: issued if it wins,
      // dropped if it loses arbitration. A new edge on the same cycle
      // re-arms the flag so it is not lost.
      pend_set   <= (pend_set && (state != IDLE)) || set_rise;
      pend_clr   <= (pend_clr && (state != IDLE)) || clr_rise;
      // Outputs decoded from the next state so they line up with the state
      // register instead of trailing it by a cycle.
      s_q        <= (state_nx == PULSE_SET);
      r_q        <= (state_nx == PULSE_CLR);
      busy_q     <= (state_nx != IDLE);
      conflict_q <= conflict_nx;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;

endmodule : sr_cmd_gen
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_cmd_gen
//  Description : Directed self-checking bench for sr_cmd_gen. Three DUTs:
//                u_dut0 D=4 P=1 clear-priority, u_dut1 D=4 P=1 set-priority,
//                u_dut2 D=4 P=3 clear-priority.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sr_cmd_gen_if bus0 ();
  sr_cmd_gen_if bus1 ();
  sr_cmd_gen_if bus2 ();

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1), .SET_PRIORITY(1'b0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1), .SET_PRIORITY(1'b1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .SET_PRIORITY(1'b0))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all(input int n);
    bus0.set_req = 1'b0; bus0.clr_req = 1'b0;
    bus1.set_req = 1'b0; bus1.clr_req = 1'b0;
    bus2.set_req = 1'b0; bus2.clr_req = 1'b0;
    repeat (n) tick();
  endtask

  int run_s [3];
  int run_r [3];
  int plen  [3];

  initial begin
    plen[0] = 1; plen[1] = 1; plen[2] = 3;
    rst = 1'b1;
    bus0.set_req = 1'b0; bus0.clr_req = 1'b0;
    bus1.set_req = 1'b0; bus1.clr_req = 1'b0;
    bus2.set_req = 1'b0; bus2.clr_req = 1'b0;
    #23;
    chk("reset_dut0", {bus0.s, bus0.r, bus0.busy, bus0.conflict}, 4'b0000);
    chk("reset_dut1", {bus1.s, bus1.r, bus1.busy, bus1.conflict}, 4'b0000);
    chk("reset_dut2", {bus2.s, bus2.r, bus2.busy, bus2.conflict}, 4'b0000);
    rst = 1'b0;
    tick();

    // ---- Clean set: s after edge 7 for one cycle, then GAP ----
    bus0.set_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("clean_s_e%0d", k), bus0.s, (k == 7));
      chk($sformatf("clean_busy_e%0d", k), bus0.busy, (k == 7 || k == 8));
      chk($sformatf("clean_r_conf_e%0d", k), {bus0.r, bus0.conflict}, 2'b00);
    end
    idle_all(12);
    chk("clean_fall_ignored", {bus0.s, bus0.r, bus0.busy}, 3'b000);

    // ---- Bounce rejected on clr_req ----
    for (int k = 0; k < 4; k++) begin
      bus0.clr_req = (k % 2 == 0);
      tick();
      chk($sformatf("bounce_cnt_t%0d", k), (u_dut0.u_clr_db.cnt < 4), 1'b1);
    end
    bus0.clr_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("bounce_r_t%0d", k), bus0.r, 1'b0);
      chk($sformatf("bounce_cnt2_t%0d", k), (u_dut0.u_clr_db.cnt < 4), 1'b1);
    end

    // ---- Simultaneous requests on both priority variants ----
    bus0.set_req = 1'b1; bus0.clr_req = 1'b1;
    bus1.set_req = 1'b1; bus1.clr_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("sim_p0_e%0d", k), {bus0.s, bus0.r, bus0.conflict}, {1'b0, (k == 7), (k == 7)});
      chk($sformatf("sim_p1_e%0d", k), {bus1.s, bus1.r, bus1.conflict}, {(k == 7), 1'b0, (k == 7)});
    end
    bus0.set_req = 1'b0; bus0.clr_req = 1'b0;
    bus1.set_req = 1'b0; bus1.clr_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("sim_loser_p0_t%0d", k), bus0.s, 1'b0);
      chk($sformatf("sim_loser_p1_t%0d", k), bus1.r, 1'b0);
    end

    // ---- Queued clear during a 3-cycle set pulse ----
    // Set pulse on edges 7..9, GAP after 10, IDLE after 11, clear pulse 12..14.
    bus2.set_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) bus2.clr_req = 1'b1;
      chk($sformatf("queue_s_e%0d", k), bus2.s, (k >= 7 && k <= 9));
      chk($sformatf("queue_r_e%0d", k), bus2.r, (k >= 12 && k <= 14));
      chk($sformatf("queue_busy_e%0d", k), bus2.busy,
          ((k >= 7 && k <= 10) || (k >= 12 && k <= 15)));
      chk($sformatf("queue_conf_e%0d", k), bus2.conflict, 1'b0);
    end
    idle_all(12);

    // ---- Asynchronous reset mid-pulse ----
    bus0.set_req = 1'b1;
    repeat (7) tick();
    chk("rst_pre_s", bus0.s, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_s_busy", {bus0.s, bus0.busy}, 2'b00);
    bus0.set_req = 1'b0;
    #3;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("rst_quiet_t%0d", k), {bus0.s, bus0.busy}, 2'b00);
    end
    bus0.set_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("rst_new_edge_e%0d", k), bus0.s, (k == 7));
    end
    idle_all(12);

    // ---- Random toggling: exclusivity and pulse width ----
    for (int i = 0; i < 3; i++) begin
      run_s[i] = 0;
      run_r[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) bus0.set_req = ~bus0.set_req;
      if ($urandom_range(0, 7) == 0) bus0.clr_req = ~bus0.clr_req;
      if ($urandom_range(0, 7) == 0) bus1.set_req = ~bus1.set_req;
      if ($urandom_range(0, 7) == 0) bus1.clr_req = ~bus1.clr_req;
      if ($urandom_range(0, 7) == 0) bus2.set_req = ~bus2.set_req;
      if ($urandom_range(0, 7) == 0) bus2.clr_req = ~bus2.clr_req;
      tick();
      for (int i = 0; i < 3; i++) begin
        logic so;
        logic ro;
        so = (i == 0) ? bus0.s : (i == 1) ? bus1.s : bus2.s;
        ro = (i == 0) ? bus0.r : (i == 1) ? bus1.r : bus2.r;
        chk($sformatf("rand_excl_dut%0d", i), so & ro, 1'b0);
        if (so) run_s[i]++;
        else if (run_s[i] != 0) begin
          chk($sformatf("rand_slen_dut%0d", i), run_s[i], plen[i]);
          run_s[i] = 0;
        end
        if (ro) run_r[i]++;
        else if (run_r[i] != 0) begin
          chk($sformatf("rand_rlen_dut%0d", i), run_r[i], plen[i]);
          run_r[i] = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sr_cmd_gen
`default_nettype wire
